// File: rtl/tick_pipe_adder.sv
// Two-stage split-carry adder stepped by rising edges of a synchronized divided clock.
// div_clk is sampled as data only; every flop runs on clk.
module tick_pipe_adder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_clk,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             step
);

    localparam int L = WIDTH / 2;
    localparam int U = WIDTH - L;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    logic         s1_valid_q, s1_valid_d;
    logic [L-1:0] lo_q, lo_d;
    logic         c1_q, c1_d;
    logic [U-1:0] ahi_q, ahi_d;
    logic [U-1:0] bhi_q, bhi_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic         s2_free, s1_free, adv2, take_in, take_out;
    logic [L:0]   lo_full;
    logic [U:0]   hi_full;

    assign step     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign s2_free  = ~s2_valid_q | out_ready;
    assign adv2     = step & s1_valid_q & s2_free;
    assign s1_free  = ~s1_valid_q | adv2;
    assign in_ready = step & s1_free;
    assign take_in  = in_valid & in_ready;
    assign take_out = s2_valid_q & out_ready;

    assign sum_out   = sum_q;
    assign cout      = cout_q;
    assign out_valid = s2_valid_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], div_clk};
        prev_d = sync_q[SYNC_STAGES-1];

        lo_full = {1'b0, a_in[L-1:0]} + {1'b0, b_in[L-1:0]}
                + {{L{1'b0}}, cin};
        hi_full = {1'b0, ahi_q} + {1'b0, bhi_q} + {{U{1'b0}}, c1_q};

        s1_valid_d = s1_valid_q;
        lo_d       = lo_q;
        c1_d       = c1_q;
        ahi_d      = ahi_q;
        bhi_d      = bhi_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;

        // Stage 2 fills before stage 1 reloads, so a same-step hand-off is safe.
        if (adv2) begin
            s2_valid_d = 1'b1;
            sum_d      = {hi_full[U-1:0], lo_q};
            cout_d     = hi_full[U];
        end else if (take_out) begin
            s2_valid_d = 1'b0;
        end

        if (take_in) begin
            s1_valid_d = 1'b1;
            lo_d       = lo_full[L-1:0];
            c1_d       = lo_full[L];
            ahi_d      = a_in[WIDTH-1:L];
            bhi_d      = b_in[WIDTH-1:L];
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            lo_q       <= '0;
            c1_q       <= 1'b0;
            ahi_q      <= '0;
            bhi_q      <= '0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            s1_valid_q <= s1_valid_d;
            lo_q       <= lo_d;
            c1_q       <= c1_d;
            ahi_q      <= ahi_d;
            bhi_q      <= bhi_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
        end
    end

endmodule

// File: tb/tb_tick_pipe_adder.sv
// Directed bench for tick_pipe_adder: vector table plus reset, backpressure,
// idle-divider and async-reset sequences.
module tb_tick_pipe_adder;

    localparam int W  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         div_clk = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         step;

    int tests = 0;
    int fails = 0;
    int dcnt  = 0;
    bit div_run = 1'b1;

    tick_pipe_adder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
        .a_in(a_in), .b_in(b_in), .cin(cin),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum_out(sum_out), .cout(cout), .out_valid(out_valid),
        .out_ready(out_ready), .step(step)
    );

    always #5 clk = ~clk;

    // Divided clock: period of 8 clk while running.
    initial forever begin
        @(negedge clk);
        if (div_run) begin
            dcnt++;
            if (dcnt >= 4) begin
                dcnt = 0;
                div_clk = ~div_clk;
            end
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_step();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            #1;
            if (step) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL step_timeout: got no step expected step");
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        wait_step();
        a_in = v.a; b_in = v.b; cin = v.ci; in_valid = 1'b1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_step();
        chk({tag, "_not_early"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum_out, v.s);
        chk({tag, "_cout"}, cout, v.co);
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        int k, got, bad;
        bit acc;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'h0F, 8'h00, 1'b1, 8'h10, 1'b0};
        vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};

        // Reset held with div_clk toggling and operands offered
        in_valid = 1'b1; a_in = 8'hAA; b_in = 8'h55;
        repeat (20) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_step", step, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);

        div_run = 1'b0; div_clk = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        div_clk = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            k++;
            if (step) break;
        end
        chk("step_latency", k, SS);
        @(negedge clk);
        #1;
        chk("step_one_cycle", step, 0);
        div_clk = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (step) bad++;
        end
        chk("fall_no_step", bad, 0);

        dcnt = 0; div_run = 1'b1;
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: third operand set must stall until the output drains
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_step();
        a_in = 8'h11; b_in = 8'h22; cin = 1'b0; in_valid = 1'b1;
        chk("bp_acc_x", in_ready, 1);
        @(posedge clk);
        #1 begin a_in = 8'hF0; b_in = 8'h20; cin = 1'b0; end
        wait_step();
        chk("bp_acc_y", in_ready, 1);
        @(posedge clk);
        #1 begin a_in = 8'h01; b_in = 8'h02; cin = 1'b1; end
        wait_step();
        chk("bp_hold_z", in_ready, 0);
        chk("bp_x_valid", out_valid, 1);
        chk("bp_x_sum", sum_out, 8'h33);
        wait_step();
        chk("bp_hold_z2", in_ready, 0);
        chk("bp_x_stable", sum_out, 8'h33);
        chk("bp_x_cout", cout, 0);
        @(negedge clk);
        out_ready = 1'b1;
        exp_q = '{8'h33, 8'h10, 8'h04};
        got = 0; acc = 1'b0;
        for (int i = 0; i < 60 && got < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (acc) begin in_valid = 1'b0; acc = 1'b0; end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_order%0d", got), sum_out, exp_q[got]);
                got++;
            end
            if (in_valid && in_ready) acc = 1'b1;
        end
        chk("bp_count", got, 3);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // Divider stuck high, then stuck low: nothing may move
        wait_step();
        @(negedge clk);
        div_run = 1'b0; div_clk = 1'b1;
        a_in = 8'h12; b_in = 8'h34; cin = 1'b0; in_valid = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (step || in_ready || out_valid) bad++;
        end
        chk("idle_high", bad, 0);
        div_clk = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (step || in_ready || out_valid) bad++;
        end
        chk("idle_low", bad, 0);
        in_valid = 1'b0; dcnt = 0; div_run = 1'b1;

        // Async reset with both stages full
        out_ready = 1'b0;
        wait_step();
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a_in = 8'h02;
        wait_step();
        chk("ar_acc2", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_drop", out_valid, 0);
        chk("ar_sum_clr", sum_out, 0);
        chk("ar_cout_clr", cout, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (out_valid) bad++;
        end
        chk("ar_no_stale", bad, 0);
        run_vec(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
